// File: rtl/butterfly_weight_buffer.sv
// Weight store for a butterfly engine. The buffer takes one complete
// weight set for a given transform length through the up_weight
// handshake. It can then replay that set any number of times through the
// dn_weight handshake, tagging each word with its stage position.
module butterfly_weight_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int BU_PARALLELISM = 4,
  parameter int MAX_LENGTH     = 1024
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [15:0]                              length,
  input  logic                                     load_start,
  input  logic                                     up_weight_vld,
  input  logic [DATA_WIDTH*4*BU_PARALLELISM-1:0]   up_weight_dat,
  output logic                                     up_weight_rdy,
  input  logic                                     rd_start,
  output logic                                     dn_weight_vld,
  output logic [DATA_WIDTH*4*BU_PARALLELISM-1:0]   dn_weight_dat,
  input  logic                                     dn_weight_rdy,
  output logic [3:0]                               dn_stage,
  output logic                                     dn_stage_last,
  output logic                                     dn_last,
  output logic                                     loaded,
  output logic                                     len_err
);

  localparam int W         = DATA_WIDTH * 4 * BU_PARALLELISM;
  localparam int LOG2_MAX  = $clog2(MAX_LENGTH);
  localparam int MIN_LEN   = 2 * BU_PARALLELISM;
  localparam int MAX_WORDS = LOG2_MAX * MAX_LENGTH / MIN_LEN;
  localparam int AW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Weight storage; deliberately not reset, validity is tracked by state.
  logic [W-1:0] mem [MAX_WORDS];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] total_m1;
  logic [15:0]   depth_m1;
  logic [15:0]   in_stage;
  logic [3:0]    stage_q;
  logic          len_err_q;
  logic [W-1:0]  dn_dat_q;

  // Length decode
  logic [4:0]    len_log2;
  logic          len_pow2;
  logic          len_ok;
  logic [15:0]   depth_new;
  logic [AW-1:0] total_m1_new;

  // Handshake qualifiers
  logic          ld_acc;
  logic          ld_go;
  logic          ld_bad;
  logic          wr_fire;
  logic          wr_done;
  logic          rd_go;
  logic          dn_fire;
  logic          dn_done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  // Decode the requested length into depth, stage count and total words.
  always_comb begin
    len_log2 = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (length[i]) len_log2 = 5'(i);
    end
    len_pow2     = (length != '0) && ((length & (length - 16'd1)) == '0);
    len_ok       = len_pow2 && ({16'd0, length} >= 32'(MIN_LEN))
                            && ({16'd0, length} <= 32'(MAX_LENGTH));
    depth_new    = length / 16'(MIN_LEN);
    total_m1_new = AW'(({16'd0, depth_new} * {27'd0, len_log2}) - 32'd1);
  end

  // Qualify the control pulses and handshakes against the current state.
  always_comb begin
    ld_acc  = load_start && ((state == IDLE) || (state == LOADED));
    ld_go   = ld_acc && len_ok;
    ld_bad  = ld_acc && !len_ok;
    wr_fire = (state == LOAD) && up_weight_vld;
    wr_done = wr_fire && (wr_ptr == total_m1);
    // load_start takes priority over rd_start in the same cycle
    rd_go   = (state == LOADED) && rd_start && !load_start;
    dn_fire = (state == STREAM) && dn_weight_rdy;
    dn_done = dn_fire && (rd_ptr == total_m1);
    // The read is registered. The word for address 0 is fetched on rd_start
    // itself, and each accepted word prefetches its successor. Together this
    // gives one-cycle start latency and no bubbles.
    rd_en   = rd_go || (dn_fire && !dn_done);
    rd_addr = rd_go ? '0 : rd_ptr + AW'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ld_go) state_nxt = LOAD;
      LOAD:    if (wr_done) state_nxt = LOADED;
      LOADED: begin
        if (ld_go)      state_nxt = LOAD;
        else if (rd_go) state_nxt = STREAM;
      end
      STREAM:  if (dn_done) state_nxt = LOADED;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the transform geometry and advance the write pointer during a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      total_m1  <= '0;
      depth_m1  <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= ld_bad;
      if (ld_go) begin
        wr_ptr   <= '0;
        total_m1 <= total_m1_new;
        depth_m1 <= depth_new - 16'd1;
      end else if (wr_fire) begin
        wr_ptr   <= wr_ptr + AW'(1);
      end
    end
  end

  // Write accepted weights into storage at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= up_weight_dat;
  end

  // Replay pointer, stage tracking and the registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      in_stage <= '0;
      stage_q  <= '0;
      dn_dat_q <= '0;
    end else begin
      if (rd_en) dn_dat_q <= mem[rd_addr];
      if (rd_go) begin
        rd_ptr   <= '0;
        in_stage <= '0;
        stage_q  <= '0;
      end else if (dn_fire && !dn_done) begin
        rd_ptr <= rd_ptr + AW'(1);
        if (in_stage == depth_m1) begin
          in_stage <= '0;
          stage_q  <= stage_q + 4'd1;
        end else begin
          in_stage <= in_stage + 16'd1;
        end
      end
    end
  end

  assign up_weight_rdy = (state == LOAD);
  assign loaded        = (state == LOADED) || (state == STREAM);
  assign len_err       = len_err_q;
  assign dn_weight_vld = (state == STREAM);
  assign dn_weight_dat = dn_dat_q;
  assign dn_stage      = stage_q;
  assign dn_stage_last = dn_weight_vld && (in_stage == depth_m1);
  assign dn_last       = dn_weight_vld && (rd_ptr == total_m1);

endmodule

// File: tb/tb_butterfly_weight_buffer.sv
// Scoreboard bench for butterfly_weight_buffer: replay stimulus pushes the
// expected words, and a negedge monitor pops and compares on every handshake.
module tb_butterfly_weight_buffer;

  localparam int DW = 16;
  localparam int BU = 4;
  localparam int ML = 1024;
  localparam int W  = DW * 4 * BU;

  typedef struct {
    logic [W-1:0] dat;
    logic [3:0]   stage;
    logic         sl;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  length;
  logic         load_start;
  logic         up_weight_vld;
  logic [W-1:0] up_weight_dat;
  logic         up_weight_rdy;
  logic         rd_start;
  logic         dn_weight_vld;
  logic [W-1:0] dn_weight_dat;
  logic         dn_weight_rdy;
  logic [3:0]   dn_stage;
  logic         dn_stage_last;
  logic         dn_last;
  logic         loaded;
  logic         len_err;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  butterfly_weight_buffer #(
    .DATA_WIDTH(DW),
    .BU_PARALLELISM(BU),
    .MAX_LENGTH(ML)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .length(length),
    .load_start(load_start),
    .up_weight_vld(up_weight_vld),
    .up_weight_dat(up_weight_dat),
    .up_weight_rdy(up_weight_rdy),
    .rd_start(rd_start),
    .dn_weight_vld(dn_weight_vld),
    .dn_weight_dat(dn_weight_dat),
    .dn_weight_rdy(dn_weight_rdy),
    .dn_stage(dn_stage),
    .dn_stage_last(dn_stage_last),
    .dn_last(dn_last),
    .loaded(loaded),
    .len_err(len_err)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] word(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: stability while stalled, and in-order scoreboard compare.
  exp_t         mon_e;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_dat;
  logic [3:0]   prev_stage;
  logic         prev_sl;
  logic         prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", W'(dn_weight_vld), W'(1));
        check("hold_dat", dn_weight_dat, prev_dat);
        check("hold_side", W'({dn_stage, dn_stage_last, dn_last}),
              W'({prev_stage, prev_sl, prev_last}));
      end
      if (dn_weight_vld && dn_weight_rdy) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h expected none", dn_weight_dat);
        end else begin
          mon_e = sb.pop_front();
          check("dn_dat", dn_weight_dat, mon_e.dat);
          check("dn_stage", W'(dn_stage), W'(mon_e.stage));
          check("dn_stage_last", W'(dn_stage_last), W'(mon_e.sl));
          check("dn_last", W'(dn_last), W'(mon_e.last));
        end
      end
      prev_stall = dn_weight_vld && !dn_weight_rdy;
      prev_dat   = dn_weight_dat;
      prev_stage = dn_stage;
      prev_sl    = dn_stage_last;
      prev_last  = dn_last;
    end
  end

  task automatic len_err_test(input logic [15:0] len, input logic exp_loaded);
    length     = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("len_err_pulse", W'(len_err), W'(1));
    check("len_err_no_load", W'(up_weight_rdy), W'(0));
    check("len_err_loaded", W'(loaded), W'(exp_loaded));
    tick();
    check("len_err_one_cycle", W'(len_err), W'(0));
  endtask

  task automatic do_load(input logic [15:0] len, input int unsigned n, input logic [15:0] base);
    length     = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_rdy", W'(up_weight_rdy), W'(1));
    check("load_loaded_low", W'(loaded), W'(0));
    for (int unsigned k = 0; k < n; k++) begin
      up_weight_vld = 1'b1;
      up_weight_dat = word(base + 16'(k));
      if (k == n - 1) check("no_partial_loaded", W'(loaded), W'(0));
      tick();
    end
    up_weight_vld = 1'b0;
    check("loaded_set", W'(loaded), W'(1));
    check("rdy_low_after_load", W'(up_weight_rdy), W'(0));
  endtask

  task automatic replay(input int total, input int depth, input logic [15:0] base,
                        input int stall_at, input int stall_len);
    exp_t e;
    int   got;
    int   cyc;
    int   bubble;
    int   stalled;
    logic hs;
    for (int k = 0; k < total; k++) begin
      e.dat   = word(base + 16'(k));
      e.stage = 4'(k / depth);
      e.sl    = (k % depth) == depth - 1;
      e.last  = (k == total - 1);
      sb.push_back(e);
    end
    dn_weight_rdy = 1'b1;
    rd_start      = 1'b1;
    tick();
    rd_start = 1'b0;
    check("first_vld_latency", W'(dn_weight_vld), W'(1));
    got = 0; cyc = 0; bubble = 0; stalled = 0;
    while (got < total && cyc < total + stall_len + 20) begin
      if (got == stall_at && stalled < stall_len) begin
        dn_weight_rdy = 1'b0;
        stalled++;
      end else begin
        dn_weight_rdy = 1'b1;
      end
      if (!dn_weight_vld) bubble++;
      hs = dn_weight_vld && dn_weight_rdy;
      tick();
      cyc++;
      if (hs) got++;
    end
    dn_weight_rdy = 1'b1;
    check("replay_count", W'(got), W'(total));
    check("no_bubbles", W'(bubble), W'(0));
    check("back_to_loaded", W'(loaded), W'(1));
    check("vld_low_after", W'(dn_weight_vld), W'(0));
    check("sb_drained", W'(sb.size()), W'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; length = '0; load_start = 1'b0; up_weight_vld = 1'b0;
    up_weight_dat = '0; rd_start = 1'b0; dn_weight_rdy = 1'b1;
    tick();
    tick();
    check("rst_up_rdy", W'(up_weight_rdy), W'(0));
    check("rst_dn_vld", W'(dn_weight_vld), W'(0));
    check("rst_stage_last", W'(dn_stage_last), W'(0));
    check("rst_last", W'(dn_last), W'(0));
    check("rst_loaded", W'(loaded), W'(0));
    check("rst_len_err", W'(len_err), W'(0));
    check("rst_stage", W'(dn_stage), W'(0));
    check("rst_dat", dn_weight_dat, '0);
    rst_n = 1'b1;
    tick();

    // rd_start in IDLE is ignored
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("idle_rd_ignored", W'(dn_weight_vld), W'(0));

    len_err_test(16'd200, 1'b0);

    // length 256: D=32, S=8, T=256
    do_load(16'd256, 256, 16'h0000);
    len_err_test(16'd4, 1'b1);
    len_err_test(16'd2048, 1'b1);
    len_err_test(16'd200, 1'b1);

    replay(256, 32, 16'h0000, 40, 5);
    replay(256, 32, 16'h0000, -1, 0);

    // load_start beats rd_start in the same LOADED cycle
    length     = 16'd256;
    load_start = 1'b1;
    rd_start   = 1'b1;
    tick();
    load_start = 1'b0;
    rd_start   = 1'b0;
    check("tie_enters_load", W'(up_weight_rdy), W'(1));
    check("tie_loaded_low", W'(loaded), W'(0));
    check("tie_no_stream", W'(dn_weight_vld), W'(0));

    for (int k = 0; k < 100; k++) begin
      up_weight_vld = 1'b1;
      up_weight_dat = word(16'h1000 + 16'(k));
      tick();
    end
    up_weight_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_loaded", W'(loaded), W'(0));
    check("abort_rdy", W'(up_weight_rdy), W'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_still_unloaded", W'(loaded), W'(0));

    // length 16: D=2, S=4, T=8
    do_load(16'd16, 8, 16'h5A00);
    replay(8, 2, 16'h5A00, -1, 0);
    replay(8, 2, 16'h5A00, 3, 2);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/butterfly_weight_buffer.md
BUTTERFLY_WEIGHT_BUFFER -- requirements
Module: butterfly_weight_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning fp16 element width.
REQ-002 SHALL have parameter BU_PARALLELISM, default 4, meaning butterfly units per engine; one weight word = 4*BU_PARALLELISM elements.
REQ-003 SHALL have parameter MAX_LENGTH, default 1024, meaning largest supported transform length (power of two).
REQ-004 SHALL have derived constants: W = DATA_WIDTH*4*BU_PARALLELISM; MAX_WORDS = log2(MAX_LENGTH)*MAX_LENGTH/(2*BU_PARALLELISM).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-007 SHALL have port length, input, 16, transform length, sampled only on an accepted load_start.
REQ-008 SHALL have port load_start, input, 1, one-cycle pulse that begins a weight load.
REQ-009 SHALL have ports up_weight_vld (input, 1), up_weight_dat (input, W) and up_weight_rdy (output, 1), the weight write handshake.
REQ-010 SHALL have port rd_start, input, 1, one-cycle pulse that begins one full replay of the stored weights.
REQ-011 SHALL have ports dn_weight_vld (output, 1), dn_weight_dat (output, W) and dn_weight_rdy (input, 1), the weight read handshake.
REQ-012 SHALL have ports dn_stage (output, 4), dn_stage_last (output, 1) and dn_last (output, 1): the stage index of the current word, the last word of a stage, and the last word of the replay.
REQ-013 SHALL have ports loaded (output, 1), the buffer holding a complete weight set, and len_err (output, 1), a one-cycle pulse on a rejected length.

Function
REQ-014 SHALL compute, on an accepted load_start: depth D = length/(2*BU_PARALLELISM); stage count S = log2(length); total T = D*S.
REQ-015 SHALL treat length as valid only if it is a power of two with 2*BU_PARALLELISM <= length <= MAX_LENGTH.
REQ-016 SHALL use a four-state FSM: IDLE, LOAD, LOADED and STREAM.
REQ-017 In IDLE or LOADED, load_start with a valid length SHALL latch D, S and T, clear wr_ptr, deassert loaded, and go to LOAD.
REQ-018 In IDLE or LOADED, load_start with an invalid length SHALL pulse len_err the next cycle and leave state and contents unchanged.
REQ-019 In LOAD, up_weight_rdy SHALL be 1; each vld&rdy cycle SHALL write up_weight_dat to address wr_ptr and increment wr_ptr.
REQ-020 In LOAD, the handshake at wr_ptr = T-1 SHALL move the FSM to LOADED and assert loaded in the following cycle.
REQ-021 In every state other than LOAD, up_weight_rdy SHALL be 0.
REQ-022 In LOADED, rd_start SHALL clear rd_ptr and go to STREAM.
REQ-023 In LOADED, when load_start and rd_start arrive in the same cycle, load_start SHALL win.
REQ-024 rd_start SHALL be ignored in IDLE, LOAD and STREAM; load_start SHALL be ignored in LOAD and STREAM.
REQ-025 In STREAM, the first dn_weight_vld SHALL assert exactly 1 cycle after rd_start, because the memory read is registered.
REQ-026 dn_weight_vld, dn_weight_dat, dn_stage, dn_stage_last and dn_last SHALL hold stable while vld=1 and rdy=0.
REQ-027 Once a STREAM transfer has begun, dn_weight_vld SHALL stay asserted with no bubbles until the final handshake, provided dn_weight_rdy stays high; sustained throughput SHALL be 1 word per clock.
REQ-028 Words SHALL be emitted in address order 0..T-1, with dn_stage = address / D.
REQ-029 dn_stage_last SHALL be 1 when address mod D = D-1; dn_last SHALL be 1 when address = T-1.
REQ-030 The dn_last handshake SHALL return the FSM to LOADED with contents retained, so unlimited replays need no reload.
REQ-031 Storage SHALL be MAX_WORDS x W; addresses >= T SHALL be neither written nor read.

Reset
REQ-032 While rst_n is 0, the FSM SHALL be IDLE and wr_ptr and rd_ptr SHALL be 0.
REQ-033 While rst_n is 0, up_weight_rdy, dn_weight_vld, dn_stage_last, dn_last, loaded and len_err SHALL be 0, and dn_stage and dn_weight_dat SHALL be 0.
REQ-034 Memory contents SHALL NOT be reset; loaded = 0 marks them invalid.
REQ-035 Reset asserted mid-LOAD or mid-STREAM SHALL abort immediately; no partial set SHALL ever be reported as loaded.

Verification
REQ-036 Load and replay: length=256, BU=4 (D=32, S=8, T=256), write word k = {16{k[15:0]}} -> loaded rises after the 256th handshake; replay emits k=0..255 on consecutive cycles; dn_stage_last at k=31,63,...,255; dn_stage=7 at k=224; dn_last only at k=255.
REQ-037 Backpressure: hold dn_weight_rdy=0 for 5 cycles at word 40 -> word 40 and its sidebands are held stable; word 41 follows on the first cycle with rdy=1; no word is lost or duplicated.
REQ-038 Length errors: length=200, then length=4, then length=2048 with MAX_LENGTH=1024 -> len_err pulses each time; state and loaded are unchanged.
REQ-039 Replay without reload: two back-to-back rd_start replays -> identical 256-word sequences; load_start and rd_start in the same LOADED cycle -> the FSM enters LOAD.
REQ-040 Reset mid-operation: drop rst_n at wr_ptr=100 -> loaded=0 and up_weight_rdy=0; a fresh length=16 load (D=2, S=4, T=8) then replays 8 words with dn_last on word 7.
